// File: rtl/reg_write_sequencer.sv
// rtl/reg_write_sequencer.sv - queued register-write master with strobe spacing and timed waits
module reg_write_sequencer #(
  parameter int DEPTH = 4,
  parameter int GAP   = 2,
  parameter int TICK  = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_addr,
  input  logic [4:0]               cmd_data,
  output logic                     write_strobe,
  output logic [2:0]               address,
  output logic [4:0]               data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TICK);
  localparam int WW = 5 + TW;
  localparam int GW = $clog2(GAP + 1);
  localparam int CW = (WW > GW) ? WW : GW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GAP  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [2:0]    headAddr;
  logic [4:0]    headData;

  assign cmd_ready = (fifo_level != LW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  // Pops only from IDLE, so an entry pushed this cycle is never bypassed.
  assign pop       = (state == ST_IDLE) && (fifo_level != '0);
  assign headAddr  = mem[rdPtr][7:5];
  assign headData  = mem[rdPtr][4:0];
  assign busy      = (state != ST_IDLE) || (fifo_level != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= {cmd_addr, cmd_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      count        <= '0;
      write_strobe <= 1'b0;
      address      <= '0;
      data         <= '0;
    end else begin
      write_strobe <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            if (headAddr != 3'd7) begin
              write_strobe <= 1'b1;
              address      <= headAddr;
              data         <= headData;
              if (GAP > 0) begin
                state <= ST_GAP;
                count <= CW'(GAP);
              end
            end else if (headData != 5'd0) begin
              // Wait length is n*TICK; TICK is a power of two so this is a shift.
              state <= ST_WAIT;
              count <= CW'(headData) << TW;
            end
          end
        end
        ST_GAP, ST_WAIT: begin
          if (count == CW'(1)) begin
            state <= ST_IDLE;
          end
          count <= count - CW'(1);
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_sequencer.sv
// tb/tb_reg_write_sequencer.sv - self-checking bench for reg_write_sequencer
module tb_reg_write_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       v0, r0, ws0, bz0;
  logic [2:0] ca0, ad0;
  logic [4:0] cd0, da0;
  logic [2:0] lv0;
  logic       v1, r1, ws1, bz1;
  logic [2:0] ca1, ad1;
  logic [4:0] cd1, da1;
  logic [1:0] lv1;

  reg_write_sequencer u0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v0), .cmd_ready(r0), .cmd_addr(ca0), .cmd_data(cd0),
    .write_strobe(ws0), .address(ad0), .data(da0), .busy(bz0), .fifo_level(lv0)
  );

  reg_write_sequencer #(.DEPTH(2), .GAP(0), .TICK(4)) u1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v1), .cmd_ready(r1), .cmd_addr(ca1), .cmd_data(cd1),
    .write_strobe(ws1), .address(ad1), .data(da1), .busy(bz1), .fifo_level(lv1)
  );

  int total = 0;
  int bad = 0;
  int strobeCount;
  logic [7:0] pend[$];
  logic       lgStr  [1024];
  logic [2:0] lgA    [1024];
  logic [4:0] lgD    [1024];
  logic       lgBusy [1024];
  logic       lgRdy  [1024];
  int         lgLvl  [1024];

  task automatic driveIn(input int sel, input logic v, input logic [2:0] a, input logic [4:0] d);
    v0 = 1'b0; ca0 = '0; cd0 = '0;
    v1 = 1'b0; ca1 = '0; cd1 = '0;
    if (sel == 0) begin v0 = v; ca0 = a; cd0 = d; end
    else begin v1 = v; ca1 = a; cd1 = d; end
  endtask

  task automatic sampleOut(input int sel, output logic s, output logic [2:0] a, output logic [4:0] d,
                           output logic b, output int l, output logic r);
    if (sel == 0) begin s = ws0; a = ad0; d = da0; b = bz0; l = int'(lv0); r = r0; end
    else begin s = ws1; a = ad1; d = da1; b = bz1; l = int'(lv1); r = r1; end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    driveIn(0, 1'b0, 3'd0, 5'd0);
    pend.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Host holds each command valid until accepted; outputs logged per cycle.
  task automatic runLog(input int sel, input int ncyc);
    logic s, b, r, acc;
    logic [2:0] a;
    logic [4:0] d;
    int l;
    strobeCount = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (pend.size() > 0) driveIn(sel, 1'b1, pend[0][7:5], pend[0][4:0]);
      else driveIn(sel, 1'b0, 3'd0, 5'd0);
      @(negedge clk);
      sampleOut(sel, s, a, d, b, l, r);
      acc = (pend.size() > 0) && r;
      if (s) strobeCount++;
      if (c < 1024) begin
        lgStr[c] = s; lgA[c] = a; lgD[c] = d; lgBusy[c] = b; lgLvl[c] = l; lgRdy[c] = r;
      end
      @(posedge clk);
      #1;
      if (acc) void'(pend.pop_front());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    driveIn(0, 1'b0, 3'd0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (ws0 !== 1'b0 || ws1 !== 1'b0) begin bad++; $display("FAIL reset_strobe got %b/%b want 0", ws0, ws1); end
    total++; if (lv0 !== 3'd0 || lv1 !== 2'd0) begin bad++; $display("FAIL reset_level got %0d/%0d want 0", lv0, lv1); end
    total++; if (r0 !== 1'b1 || r1 !== 1'b1) begin bad++; $display("FAIL reset_ready got %b/%b want 1", r0, r1); end
    total++; if (bz0 !== 1'b0 || bz1 !== 1'b0) begin bad++; $display("FAIL reset_busy got %b/%b want 0", bz0, bz1); end
    total++; if (ad0 !== 3'd0 || da0 !== 5'd0) begin bad++; $display("FAIL reset_addr_data got %0d/%0d want 0/0", ad0, da0); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    doReset();
    pend.push_back({3'd2, 5'd9});
    runLog(0, 20);
    total++; if (strobeCount !== 1) begin bad++; $display("FAIL single_count got %0d want 1", strobeCount); end
    total++; if (lgStr[2] !== 1'b1 || lgA[2] !== 3'd2 || lgD[2] !== 5'd9)
      begin bad++; $display("FAIL single_strobe got s=%b a=%0d d=%0d want 1/2/9", lgStr[2], lgA[2], lgD[2]); end
    total++; if (lgBusy[1] !== 1'b1) begin bad++; $display("FAIL single_busy1 got %b want 1", lgBusy[1]); end
    total++; if (lgBusy[4] !== 1'b0) begin bad++; $display("FAIL single_busy4 got %b want 0", lgBusy[4]); end
    total++; if (lgA[10] !== 3'd2 || lgD[10] !== 5'd9)
      begin bad++; $display("FAIL single_hold got %0d/%0d want 2/9", lgA[10], lgD[10]); end
  endtask

  task automatic test_burst();
    doReset();
    for (int i = 0; i < 6; i++) pend.push_back({3'(i), 5'(3 * i + 1)});
    runLog(0, 30);
    total++; if (strobeCount !== 6) begin bad++; $display("FAIL burst_count got %0d want 6", strobeCount); end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (lgStr[2 + 3 * k] !== 1'b1 || lgA[2 + 3 * k] !== 3'(k) || lgD[2 + 3 * k] !== 5'(3 * k + 1)) begin
        bad++;
        $display("FAIL burst_strobe%0d got s=%b a=%0d d=%0d want 1/%0d/%0d", k,
                 lgStr[2 + 3 * k], lgA[2 + 3 * k], lgD[2 + 3 * k], k, 3 * k + 1);
      end
    end
    total++; if (lgLvl[6] !== 4) begin bad++; $display("FAIL burst_level6 got %0d want 4", lgLvl[6]); end
    total++; if (lgRdy[6] !== 1'b0 || lgRdy[7] !== 1'b0) begin bad++; $display("FAIL burst_full got %b%b want 00", lgRdy[6], lgRdy[7]); end
    total++; if (lgRdy[8] !== 1'b1 || lgLvl[8] !== 3) begin bad++; $display("FAIL burst_ready8 got %b/%0d want 1/3", lgRdy[8], lgLvl[8]); end
  endtask

  task automatic test_wait();
    doReset();
    pend.push_back({3'd7, 5'd3});
    pend.push_back({3'd0, 5'd5});
    runLog(0, 800);
    total++; if (strobeCount !== 1) begin bad++; $display("FAIL wait_count got %0d want 1", strobeCount); end
    total++; if (lgStr[771] !== 1'b1 || lgA[771] !== 3'd0 || lgD[771] !== 5'd5)
      begin bad++; $display("FAIL wait_strobe got s=%b a=%0d d=%0d want 1/0/5", lgStr[771], lgA[771], lgD[771]); end
    total++; if (lgBusy[400] !== 1'b1 || lgBusy[772] !== 1'b1)
      begin bad++; $display("FAIL wait_busy got %b%b want 11", lgBusy[400], lgBusy[772]); end
    total++; if (lgBusy[773] !== 1'b0) begin bad++; $display("FAIL wait_idle got %b want 0", lgBusy[773]); end
  endtask

  task automatic test_zero_wait();
    doReset();
    pend.push_back({3'd7, 5'd0});
    pend.push_back({3'd1, 5'd4});
    runLog(0, 10);
    total++; if (strobeCount !== 1) begin bad++; $display("FAIL zwait_count got %0d want 1", strobeCount); end
    total++; if (lgStr[3] !== 1'b1 || lgA[3] !== 3'd1 || lgD[3] !== 5'd4)
      begin bad++; $display("FAIL zwait_strobe got s=%b a=%0d d=%0d want 1/1/4", lgStr[3], lgA[3], lgD[3]); end
  endtask

  task automatic test_reset_mid_wait();
    doReset();
    pend.push_back({3'd5, 5'd17});
    pend.push_back({3'd7, 5'd31});
    pend.push_back({3'd1, 5'd1});
    pend.push_back({3'd2, 5'd2});
    runLog(0, 50);
    total++; if (lgA[49] !== 3'd5 || lgD[49] !== 5'd17 || lgBusy[49] !== 1'b1)
      begin bad++; $display("FAIL midwait_pre got a=%0d d=%0d b=%b want 5/17/1", lgA[49], lgD[49], lgBusy[49]); end
    #2 rst_n = 1'b0;
    driveIn(0, 1'b0, 3'd0, 5'd0);
    pend.delete();
    #1;
    total++; if (ws0 !== 1'b0 || lv0 !== 3'd0 || r0 !== 1'b1 || bz0 !== 1'b0)
      begin bad++; $display("FAIL midwait_rst got s=%b l=%0d r=%b b=%b want 0/0/1/0", ws0, lv0, r0, bz0); end
    total++; if (ad0 !== 3'd0 || da0 !== 5'd0) begin bad++; $display("FAIL midwait_rst_ad got %0d/%0d want 0/0", ad0, da0); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    runLog(0, 10000);
    total++; if (strobeCount !== 0) begin bad++; $display("FAIL midwait_after got %0d strobes want 0", strobeCount); end
  endtask

  task automatic test_gap0();
    doReset();
    pend.push_back({3'd3, 5'd1});
    pend.push_back({3'd4, 5'd2});
    runLog(1, 10);
    total++; if (strobeCount !== 2) begin bad++; $display("FAIL gap0_count got %0d want 2", strobeCount); end
    total++; if (lgStr[2] !== 1'b1 || lgA[2] !== 3'd3 || lgD[2] !== 5'd1)
      begin bad++; $display("FAIL gap0_first got s=%b a=%0d d=%0d want 1/3/1", lgStr[2], lgA[2], lgD[2]); end
    total++; if (lgStr[3] !== 1'b1 || lgA[3] !== 3'd4 || lgD[3] !== 5'd2)
      begin bad++; $display("FAIL gap0_second got s=%b a=%0d d=%0d want 1/4/2", lgStr[3], lgA[3], lgD[3]); end
  endtask

  // Reference: each command's pop = max(push+1, previous free time); the block
  // frees GAP+1 cycles after a register pop or n*TICK+1 after a wait pop.
  task automatic test_random(input int sel, input int ncmd, input int dep, input int gp, input int tk, input int maxn);
    int pushT[64], popT[64], freeT[64];
    logic [2:0] ca[64];
    logic [4:0] cd[64];
    int np, c, prevFree, lvl, p, l;
    bit val, done, expStr, expBusy;
    logic [2:0] lastA, a;
    logic [4:0] lastD, d;
    logic s, b, r;
    doReset();
    for (int i = 0; i < ncmd; i++) begin
      if ($urandom_range(0, 3) == 0 || i == 0) begin
        ca[i] = 3'd7; cd[i] = (i == 0) ? 5'(maxn) : 5'($urandom_range(0, maxn));
      end else begin
        ca[i] = 3'($urandom_range(0, 6)); cd[i] = 5'($urandom_range(0, 31));
      end
    end
    np = 0; c = 0; prevFree = 0; val = 0; done = 0; lastA = '0; lastD = '0;
    while (!done) begin
      if (!val && np < ncmd) val = ($urandom_range(0, 3) != 0);
      if (val) driveIn(sel, 1'b1, ca[np], cd[np]);
      else driveIn(sel, 1'b0, 3'd0, 5'd0);
      @(negedge clk);
      sampleOut(sel, s, a, d, b, l, r);
      lvl = 0; expStr = 0; expBusy = 0;
      for (int i = 0; i < np; i++) begin
        lvl = lvl + 1 - ((popT[i] < c) ? 1 : 0);
        if (ca[i] != 3'd7 && popT[i] + 1 == c) begin expStr = 1; lastA = ca[i]; lastD = cd[i]; end
        if (popT[i] < c && c < freeT[i]) expBusy = 1;
      end
      if (lvl > 0) expBusy = 1;
      total++; if (r !== (lvl < dep)) begin bad++; $display("FAIL rnd%0d_ready c=%0d got %b want %b", sel, c, r, lvl < dep); end
      total++; if (l !== lvl) begin bad++; $display("FAIL rnd%0d_level c=%0d got %0d want %0d", sel, c, l, lvl); end
      total++; if (s !== expStr) begin bad++; $display("FAIL rnd%0d_strobe c=%0d got %b want %b", sel, c, s, expStr); end
      total++; if (a !== lastA || d !== lastD)
        begin bad++; $display("FAIL rnd%0d_addr_data c=%0d got %0d/%0d want %0d/%0d", sel, c, a, d, lastA, lastD); end
      total++; if (b !== expBusy) begin bad++; $display("FAIL rnd%0d_busy c=%0d got %b want %b", sel, c, b, expBusy); end
      if (val && lvl < dep) begin
        pushT[np] = c;
        p = (c + 1 > prevFree) ? c + 1 : prevFree;
        popT[np] = p;
        freeT[np] = (ca[np] == 3'd7) ? p + int'(cd[np]) * tk + 1 : p + gp + 1;
        prevFree = freeT[np];
        np++;
        val = 0;
      end
      if (np == ncmd && c > prevFree + 2) done = 1;
      if (c > 30000) begin
        total++; bad++;
        $display("FAIL rnd%0d_timeout got %0d cmds want %0d", sel, np, ncmd);
        done = 1;
      end
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  initial begin
    driveIn(0, 1'b0, 3'd0, 5'd0);
    test_reset();
    test_single_write();
    test_burst();
    test_wait();
    test_zero_wait();
    test_gap0();
    test_random(0, 40, 4, 2, 256, 2);
    test_random(1, 60, 2, 0, 4, 31);
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
